inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Reads program bytes one at a time over a byte-wide req/ack memory port and assembles the 16-bit instruction word.
- Opcode byte is placed in inst[15:8]; the operand byte, when present, in inst[7:0].
- Presents the word with a valid/ready handshake (inst_valid drives decoder en); tracks the PC, accepts branch redirects from execute and stops on halt.

Parameters:
- RESET_PC, 16'h0000, address of the first opcode fetched after reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_req  out  1  byte read request
- mem_addr  out  16  byte address of current request
- mem_ack  in  1  read complete; mem_rdata valid this cycle
- mem_rdata  in  8  read data
- inst_valid  out  1  inst/inst_pc/inst_len hold a complete instruction (decoder en)
- inst_ready  in  1  execute consumes the instruction this cycle
- inst  out  16  assembled instruction word
- inst_pc  out  16  address of the instruction's opcode byte
- inst_len  out  2  1 or 2, bytes occupied by the instruction
- redirect  in  1  take branch; qualified by inst_valid & inst_ready
- redirect_pc  in  16  branch target
- halt  in  1  stop fetching; qualified by inst_valid & inst_ready
- halted  out  1  fetch stopped

Behaviour:
- States: FETCH_HI, FETCH_LO, VALID, HALTED. All outputs except mem_req/mem_addr are registered.
- Reset (any cycle, any state, overrides everything):
  - state=FETCH_HI, pc=RESET_PC, inst=0, inst_pc=0, inst_len=0, inst_valid=0, halted=0.
  - mem_req=0 while rst is high; an ack in a reset cycle is ignored.
- mem_req = (state==FETCH_HI | state==FETCH_LO) & !rst.
- mem_addr = pc in FETCH_HI, pc+1 (mod 2^16) in FETCH_LO, 0 otherwise.
- Memory handshake:
  - mem_req and mem_addr stay stable until mem_ack; any wait-state count is legal.
  - Ack may arrive in the same cycle as req (zero-wait memory).
  - mem_ack with mem_req low is ignored.
- FETCH_HI, on mem_ack, latch op=mem_rdata:
  - op[7]==0 → inst={op,8'h00}, inst_len=1, inst_pc=pc, go to VALID.
  - op[7]==1 → inst[15:8]=op, go to FETCH_LO.
- FETCH_LO, on mem_ack: inst[7:0]=mem_rdata, inst_len=2, inst_pc=pc, go to VALID.
- VALID: inst_valid=1; inst, inst_pc and inst_len are held stable until consumed.
- On inst_valid & inst_ready, priority is halt > redirect > sequential:
  - halt → HALTED, inst_valid=0, halted=1.
  - redirect → pc=redirect_pc, FETCH_HI.
  - otherwise → pc=pc+inst_len (16-bit wrap, FFFF+1=0000; FFFF with 2-byte op fetches operand from 0000), FETCH_HI.
- redirect and halt are ignored when not qualified by inst_valid & inst_ready.
- HALTED: no requests, inst_valid=0. Only rst exits this state.
- Throughput with zero-wait memory:
  - 1-byte op: 2 cycles per instruction (FETCH_HI, VALID).
  - 2-byte op: 3 cycles per instruction.
  - First inst_valid rises on the 2nd clock edge after rst deasserts for a 1-byte op.

Decomposition:
- Package fetch_pkg:
  - state enum (FETCH_HI, FETCH_LO, VALID, HALTED)
  - OP_ONE_ARG_BIT=7
  - LEN_ONE=2'd1, LEN_TWO=2'd2
- Single module; no sub-module warranted.

Test Plan:
- Reset then zero-wait memory with mem[0]=8'h01 (1-byte):
  - → mem_addr=0000 on cycle 1; inst_valid on cycle 2 with inst=16'h0100, inst_len=1, inst_pc=0000.
  - With ready held, next request is at 0001.
- mem[10]=8'h80, mem[11]=8'h2A, 3 wait states per ack:
  - → mem_addr holds 0010 until ack, then holds 0011.
  - inst=16'h802A, inst_len=2, inst_pc=0010; next fetch at 0012.
- Hold inst_ready=0 for 5 cycles in VALID → inst/inst_pc stable, no mem_req; ready=1 → advances exactly once.
- Redirect and halt:
  - Consume with redirect=1, redirect_pc=16'h0200 → next mem_addr=0200; redirect asserted while not valid has no effect.
  - Consume with halt=1 and redirect=1 → halted=1, no further mem_req, redirect ignored.
- Wrap-around:
  - pc=FFFF with 2-byte op → operand address 0000, next pc=0001.
  - pc=FFFF with 1-byte op → next pc=0000.
- Reset in mid-request:
  - rst during FETCH_LO wait, with ack in the same cycle → ack ignored, inst_valid=0.
  - Refetch starts at RESET_PC one cycle after rst falls; rst in HALTED restarts fetch.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FETCH_HI = 2'd0,
        FETCH_LO = 2'd1,
        VALID    = 2'd2,
        HALTED   = 2'd3
    } fetch_state_t;

    // Opcode bit that marks an instruction carrying an operand byte.
    localparam int OP_ONE_ARG_BIT = 7;

    // Instruction lengths in bytes.
    localparam logic [1:0] LEN_ONE = 2'd1;
    localparam logic [1:0] LEN_TWO = 2'd2;

endpackage : fetch_pkg

// File: rtl/inst_fetch_if.sv
// Bundle of the byte-wide memory port and the decoder-side instruction
// handshake. The fetch stage is the master; memory plus decoder/execute
// together form the slave side.
interface inst_fetch_if;

    // Byte-wide memory read port
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    // Instruction handshake toward decode/execute
    logic        inst_valid;
    logic        inst_ready;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic [1:0]  inst_len;

    // Control flow from execute
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        halted;

    modport master (
        output mem_req, mem_addr, inst_valid, inst, inst_pc, inst_len, halted,
        input  mem_ack, mem_rdata, inst_ready, redirect, redirect_pc, halt
    );

    modport slave (
        input  mem_req, mem_addr, inst_valid, inst, inst_pc, inst_len, halted,
        output mem_ack, mem_rdata, inst_ready, redirect, redirect_pc, halt
    );

endinterface : inst_fetch_if

// File: rtl/inst_fetch.sv
// Instruction fetch stage: reads opcode/operand bytes over a req/ack byte
// port, assembles a 16-bit word, and hands it to decode with valid/ready.
// Tracks the PC, follows branch redirects and stops on halt.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);

    fetch_state_t state_reg, state_next;
    logic [15:0]  pc_reg, pc_next;
    logic [15:0]  inst_reg, inst_next;
    logic [15:0]  inst_pc_reg, inst_pc_next;
    logic [1:0]   inst_len_reg, inst_len_next;
    logic         valid_reg, valid_next;
    logic         halted_reg, halted_next;

    // Operand byte follows the opcode; wraps from FFFF to 0000.
    logic [15:0]  pc_plus_one;
    assign pc_plus_one = pc_reg + 16'd1;

    // State register: reset overrides everything, including a pending ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FETCH_HI;
            pc_reg       <= RESET_PC;
            inst_reg     <= 16'h0000;
            inst_pc_reg  <= 16'h0000;
            inst_len_reg <= 2'd0;
            valid_reg    <= 1'b0;
            halted_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            inst_reg     <= inst_next;
            inst_pc_reg  <= inst_pc_next;
            inst_len_reg <= inst_len_next;
            valid_reg    <= valid_next;
            halted_reg   <= halted_next;
        end
    end

    // Next-state logic: byte assembly, hand-off and PC update.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        inst_next     = inst_reg;
        inst_pc_next  = inst_pc_reg;
        inst_len_next = inst_len_reg;
        valid_next    = valid_reg;
        halted_next   = halted_reg;

        case (state_reg)
            FETCH_HI: begin
                if (bus.mem_ack) begin
                    if (bus.mem_rdata[OP_ONE_ARG_BIT]) begin
                        // Operand follows; keep the opcode and go get it.
                        inst_next  = {bus.mem_rdata, inst_reg[7:0]};
                        state_next = FETCH_LO;
                    end else begin
                        inst_next     = {bus.mem_rdata, 8'h00};
                        inst_len_next = LEN_ONE;
                        inst_pc_next  = pc_reg;
                        valid_next    = 1'b1;
                        state_next    = VALID;
                    end
                end
            end

            FETCH_LO: begin
                if (bus.mem_ack) begin
                    inst_next     = {inst_reg[15:8], bus.mem_rdata};
                    inst_len_next = LEN_TWO;
                    inst_pc_next  = pc_reg;
                    valid_next    = 1'b1;
                    state_next    = VALID;
                end
            end

            VALID: begin
                // halt beats redirect beats sequential flow.
                if (bus.inst_ready) begin
                    valid_next = 1'b0;
                    if (bus.halt) begin
                        halted_next = 1'b1;
                        state_next  = HALTED;
                    end else if (bus.redirect) begin
                        pc_next    = bus.redirect_pc;
                        state_next = FETCH_HI;
                    end else begin
                        pc_next    = pc_reg + {14'd0, inst_len_reg};
                        state_next = FETCH_HI;
                    end
                end
            end

            HALTED: begin
                // Only reset leaves this state.
            end

            default: begin
                state_next = FETCH_HI;
            end
        endcase
    end

    // Memory request outputs, decoded from the current state.
    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_addr = 16'h0000;
        case (state_reg)
            FETCH_HI: begin
                bus.mem_req  = !rst;
                bus.mem_addr = pc_reg;
            end
            FETCH_LO: begin
                bus.mem_req  = !rst;
                bus.mem_addr = pc_plus_one;
            end
            default: begin
                bus.mem_req  = 1'b0;
                bus.mem_addr = 16'h0000;
            end
        endcase
    end

    assign bus.inst_valid = valid_reg;
    assign bus.inst       = inst_reg;
    assign bus.inst_pc    = inst_pc_reg;
    assign bus.inst_len   = inst_len_reg;
    assign bus.halted     = halted_reg;

endmodule : inst_fetch
